dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the pipelined datapath's MEM stage. It answers the pipeline's `MemRead`/`MemWrite` requests after a configurable number of wait states. While an access is in flight it holds `Stall` high so the pipeline keeps the request stable, then returns read data with a one-cycle `Ready` pulse. It also flags misaligned, out-of-range and conflicting requests without touching storage.

## Interface
Parameters:
- `DEPTH_WORDS`, default 64: number of 32-bit words; power of two, 4..1024.
- `WAIT_CYCLES`, default 2: wait states per access; legal range 0..15.

Ports:
- `Clk`, input, 1: single clock; all state changes on the rising edge.
- `Rst_n`, input, 1: reset, asynchronous and active-low.
- `MemRead`, input, 1: read request from the MEM stage.
- `MemWrite`, input, 1: write request from the MEM stage.
- `Address`, input, 32: byte address.
- `WriteData`, input, 32: store data.
- `ReadData`, output, 32: load data; valid when `Ready` is high, held afterwards.
- `Ready`, output, 1: one-cycle completion pulse.
- `Stall`, output, 1: freeze request from the responder to the pipeline.
- `Err`, output, 1: error flag, valid only with `Ready`.

## Operation
- FSM states are IDLE, WAIT and RESP. Reset state is IDLE.
- A request is present when `MemRead | MemWrite`.
- Request in IDLE:
  - `Address`, `WriteData` and the request type are latched.
  - The wait counter is loaded with `WAIT_CYCLES`.
  - Next state is WAIT, or RESP when `WAIT_CYCLES` = 0.
- WAIT: the counter decrements each cycle. At count 1 the next state is RESP.
- Commit happens on the edge entering RESP:
  - A write stores `WriteData` at word `Address[log2(DEPTH_WORDS)+1:2]`.
  - A read loads `ReadData` from that same word.
- RESP: `Ready` = 1 for exactly one cycle, then IDLE. Inputs sampled in RESP are ignored.
- Error cases (no storage access in any of them; `ReadData` ← 0; `Err` = 1 with `Ready`):
  - `Address[1:0]` ≠ 0 (misaligned).
  - `Address` ≥ 4·`DEPTH_WORDS` (out of range).
  - `MemRead` and `MemWrite` both asserted (conflict).
  - Error requests still take the full wait latency.
- `Stall` = (IDLE && request && `WAIT_CYCLES` ≠ 0) || WAIT. It is low in RESP, so the pipeline advances at the end of RESP.
- Back-to-back requests:
  - The next request is seen in the IDLE cycle following RESP.
  - Sustained throughput is one access per `WAIT_CYCLES`+2 cycles.

## Timing
- Request asserted in cycle N: `Ready` is high in cycle N+`WAIT_CYCLES`+1.
- `Stall` is high in cycles N..N+`WAIT_CYCLES` (never high when `WAIT_CYCLES` = 0).
- `ReadData` is registered; it changes only on the RESP-entry edge.
- Reset values: `ReadData` = 0, `Ready` = 0, `Err` = 0, `Stall` = 0, FSM = IDLE, counter = 0.
- Memory contents are not cleared by reset.
- Reset mid-access (WAIT or RESP): the FSM returns to IDLE immediately. A pending write is discarded and never committed.
- Requests stay stable while `Stall` is high; the responder uses only its latched copy after IDLE.
- The counter is 4 bits and never wraps, because it is reloaded only in IDLE.

## Structure
- Shared package `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, WAIT, RESP};
  - `DMEM_DATA_W` = 32;
  - `DMEM_CNT_W` = 4.
- Sub-module `dmem_array`:
  - synchronous single-port 32-bit RAM;
  - inputs: write enable, word index, write data;
  - output: registered read data;
  - no reset.
- FSM, counter, error decode and `Stall` logic live in `dmem_responder`.

## Test plan
- Write then read (`WAIT_CYCLES`=2): write 0xDEADBEEF to address 0x10; `Stall` high for 3 cycles, `Ready` in the 3rd cycle after the request. A following read of 0x10 returns 0xDEADBEEF with `Err`=0.
- Zero-wait (`WAIT_CYCLES`=0): read of address 0x0 after writing 0x12345678 there; `Stall` never high, `Ready` the cycle after the request, `ReadData`=0x12345678.
- Misaligned: read of address 0x13 → `Ready` with `Err`=1 and `ReadData`=0; word 0x10 remains 0xDEADBEEF.
- Range and conflict (`DEPTH_WORDS`=64):
  - write to address 0x100 → `Err`=1, no store;
  - `MemRead` and `MemWrite` both high at address 0x20 → `Err`=1, word 0x20 unchanged.
- Reset mid-write: write 0xCAFEF00D to address 0x24, pull `Rst_n` low during WAIT. Outputs go to zero immediately; a later read of 0x24 returns the prior contents, not 0xCAFEF00D.
- Back-to-back: 4 consecutive reads with `WAIT_CYCLES`=1 → `Ready` pulses exactly 3 cycles apart; no request is lost or duplicated.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM. Read is read-before-write and registered;
// storage has no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_idx,
  input  logic [DMEM_DATA_W-1:0] i_wdata,
  output logic [DMEM_DATA_W-1:0] o_rdata
);

  logic [DMEM_DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DMEM_DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
    r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: holds Stall for WAIT_CYCLES wait states,
// commits the access on the edge into RESP and pulses Ready for one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic [DMEM_DATA_W-1:0] Address,
  input  logic [DMEM_DATA_W-1:0] WriteData,
  output logic [DMEM_DATA_W-1:0] ReadData,
  output logic                   Ready,
  output logic                   Stall,
  output logic                   Err,
  output dmem_state_t            o_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_CNT_W-1:0] LP_WAIT = DMEM_CNT_W'(WAIT_CYCLES);

  dmem_state_t            r_state;
  dmem_state_t            w_next;
  logic [DMEM_CNT_W-1:0]  r_cnt;
  logic [DMEM_DATA_W-1:0] r_addr;
  logic [DMEM_DATA_W-1:0] r_wdata;
  logic                   r_rd;
  logic                   r_wr;
  logic                   r_err;
  logic [DMEM_DATA_W-1:0] r_rdata_hold;

  logic                   w_req;
  logic                   w_idle;
  logic [DMEM_DATA_W-1:0] w_addr;
  logic [DMEM_DATA_W-1:0] w_wdata;
  logic                   w_rd;
  logic                   w_wr;
  logic                   w_err;
  logic                   w_commit;
  logic                   w_we;
  logic [DMEM_DATA_W-1:0] w_arr_rdata;
  logic [DMEM_DATA_W-1:0] w_resp_data;

  assign w_req  = MemRead | MemWrite;
  assign w_idle = (r_state == IDLE);

  // With zero wait states the commit edge is also the latch edge, so the
  // live inputs are used in IDLE and the latched copy everywhere else.
  assign w_addr  = w_idle ? Address   : r_addr;
  assign w_wdata = w_idle ? WriteData : r_wdata;
  assign w_rd    = w_idle ? MemRead   : r_rd;
  assign w_wr    = w_idle ? MemWrite  : r_wr;

  assign w_err = (w_addr[1:0] != 2'b00) || (w_addr[DMEM_DATA_W-1:AW+2] != '0) || (w_rd && w_wr);

  assign w_commit = (r_state != RESP) && (w_next == RESP);
  assign w_we     = w_commit && w_wr && !w_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .i_clk   (Clk),
    .i_we    (w_we),
    .i_idx   (w_addr[AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_req) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (r_cnt <= 4'd1) w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_err        <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      if (w_idle && w_req) begin
        r_cnt   <= LP_WAIT;
        r_addr  <= Address;
        r_wdata <= WriteData;
        r_rd    <= MemRead;
        r_wr    <= MemWrite;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        r_err <= w_err;
      end
      if (r_state == RESP) begin
        r_rdata_hold <= w_resp_data;
      end
    end
  end

  // Writes leave ReadData untouched; errors force it to zero.
  assign w_resp_data = r_err ? '0 : (r_rd ? w_arr_rdata : r_rdata_hold);

  always_comb begin
    Ready    = (r_state == RESP);
    Err      = (r_state == RESP) && r_err;
    Stall    = (w_idle && w_req && (WAIT_CYCLES != 0)) || (r_state == WAIT);
    ReadData = (r_state == RESP) ? w_resp_data : r_rdata_hold;
    o_state  = r_state;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 2, 0 and 1 wait states.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        mem_read  [3];
  logic        mem_write [3];
  logic [31:0] addr      [3];
  logic [31:0] wdata     [3];
  logic [31:0] rdata     [3];
  logic        ready     [3];
  logic        stall     [3];
  logic        err       [3];
  dmem_state_t st        [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_w2 (
    .Clk(clk), .Rst_n(rst_n[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .Address(addr[0]), .WriteData(wdata[0]), .ReadData(rdata[0]), .Ready(ready[0]),
    .Stall(stall[0]), .Err(err[0]), .o_state(st[0])
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_w0 (
    .Clk(clk), .Rst_n(rst_n[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .Address(addr[1]), .WriteData(wdata[1]), .ReadData(rdata[1]), .Ready(ready[1]),
    .Stall(stall[1]), .Err(err[1]), .o_state(st[1])
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1)) u_w1 (
    .Clk(clk), .Rst_n(rst_n[2]), .MemRead(mem_read[2]), .MemWrite(mem_write[2]),
    .Address(addr[2]), .WriteData(wdata[2]), .ReadData(rdata[2]), .Ready(ready[2]),
    .Stall(stall[2]), .Err(err[2]), .o_state(st[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request; lat is the cycle offset of Ready (-1 if it never came).
  task automatic access(input int k, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q, output logic e,
                        output int lat, output int nstall);
    @(negedge clk);
    mem_read[k]  = rd;
    mem_write[k] = wr;
    addr[k]      = a;
    wdata[k]     = d;
    lat = -1; nstall = 0; q = '0; e = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall[k]) nstall++;
      if (ready[k]) begin
        lat = c;
        q   = rdata[k];
        e   = err[k];
        break;
      end
      @(negedge clk);
    end
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b0;
  endtask

  logic [31:0] q;
  logic        e;
  int          lat, ns;

  initial begin
    int nr, last, extra;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; mem_read[k] = 1'b0; mem_write[k] = 1'b0;
      addr[k] = '0; wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
      check($sformatf("rst_ready%0d", k), {31'b0, ready[k]}, 32'h0);
      check($sformatf("rst_err%0d", k), {31'b0, err[k]}, 32'h0);
      check($sformatf("rst_stall%0d", k), {31'b0, stall[k]}, 32'h0);
      check($sformatf("rst_state%0d", k), {30'b0, st[k]}, {30'b0, IDLE});
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

    // Two wait states: write then read back.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, q, e, lat, ns);
    check("w2_wr_lat", lat, 3);
    check("w2_wr_stall", ns, 3);
    check("w2_wr_err", {31'b0, e}, 0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, q, e, lat, ns);
    check("w2_rd_data", q, 32'hDEADBEEF);
    check("w2_rd_err", {31'b0, e}, 0);
    check("w2_rd_lat", lat, 3);

    // Zero wait states.
    access(1, 1'b0, 1'b1, 32'h0, 32'h12345678, q, e, lat, ns);
    check("w0_wr_lat", lat, 1);
    check("w0_wr_stall", ns, 0);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, q, e, lat, ns);
    check("w0_rd_data", q, 32'h12345678);
    check("w0_rd_lat", lat, 1);
    check("w0_rd_stall", ns, 0);

    // Misaligned read, then the aligned word is intact and held after Ready.
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, q, e, lat, ns);
    check("mis_err", {31'b0, e}, 1);
    check("mis_data", q, 32'h0);
    check("mis_lat", lat, 3);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, q, e, lat, ns);
    check("mis_keep", q, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    #1;
    check("hold_data", rdata[0], 32'hDEADBEEF);
    check("hold_ready", {31'b0, ready[0]}, 0);

    // Out of range: 0x100 would alias word 0 if it were stored.
    access(0, 1'b0, 1'b1, 32'h0, 32'hA5A50000, q, e, lat, ns);
    access(0, 1'b0, 1'b1, 32'h100, 32'hBAD00100, q, e, lat, ns);
    check("rng_err", {31'b0, e}, 1);
    check("rng_lat", lat, 3);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, q, e, lat, ns);
    check("rng_nostore", q, 32'hA5A50000);

    // Conflicting read+write.
    access(0, 1'b0, 1'b1, 32'h20, 32'h20202020, q, e, lat, ns);
    access(0, 1'b1, 1'b1, 32'h20, 32'hBAD00020, q, e, lat, ns);
    check("cfl_err", {31'b0, e}, 1);
    check("cfl_data", q, 32'h0);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, q, e, lat, ns);
    check("cfl_nostore", q, 32'h20202020);

    // Reset during WAIT discards the pending write.
    access(0, 1'b0, 1'b1, 32'h24, 32'h11112222, q, e, lat, ns);
    @(negedge clk);
    mem_write[0] = 1'b1; addr[0] = 32'h24; wdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    check("mid_stall", {31'b0, stall[0]}, 1);
    check("mid_state", {30'b0, st[0]}, {30'b0, WAIT});
    rst_n[0] = 1'b0;
    mem_write[0] = 1'b0;
    #1;
    check("mid_rst_rdata", rdata[0], 32'h0);
    check("mid_rst_ready", {31'b0, ready[0]}, 0);
    check("mid_rst_stall", {31'b0, stall[0]}, 0);
    check("mid_rst_err", {31'b0, err[0]}, 0);
    check("mid_rst_state", {30'b0, st[0]}, {30'b0, IDLE});
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    access(0, 1'b1, 1'b0, 32'h24, 32'h0, q, e, lat, ns);
    check("mid_prior", q, 32'h11112222);

    // Back-to-back reads, one wait state.
    for (int i = 0; i < 4; i++)
      access(2, 1'b0, 1'b1, 32'h40 + 32'(4 * i), 32'hB0B00000 + 32'(i), q, e, lat, ns);
    @(negedge clk);
    mem_read[2] = 1'b1; addr[2] = 32'h40;
    nr = 0; last = -1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (ready[2]) begin
        check($sformatf("b2b_data%0d", nr), rdata[2], 32'hB0B00000 + 32'(nr));
        if (nr == 0) check("b2b_first_lat", c, 2);
        else check($sformatf("b2b_gap%0d", nr), c - last, 3);
        last = c;
        nr++;
        if (nr < 4) addr[2] = 32'h40 + 32'(4 * nr);
        else mem_read[2] = 1'b0;
      end
      if (nr == 4) break;
      @(negedge clk);
    end
    check("b2b_count", nr, 4);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (ready[2]) extra++;
    end
    check("b2b_no_extra", extra, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
